toggle_walk_fsm: RTL
====================

// Module: toggle_walk_fsm
// PURPOSE
//   Parametrised successor to the team's 4-state toggle FSM. The state is STATE_W bits wide.
//   Each accepted input toggles the one state bit chosen by sel.
//   With STATE_W=2 and sel=A it reproduces the original 2-bit behaviour: A=0 toggles bit0,
//   A=1 toggles bit1, and y equals A.
//   Adds an accept handshake, illegal-selector capture and detection of ping-pong
//   oscillation between two states. Sits in the FSM-logic library as a reusable
//   sequence-driven state walker.
// PARAMETERS
//   STATE_W     2   state bits; number of states = 2**STATE_W; legal range 2..16
//   SEL_W       1   selector width; must be >= $clog2(STATE_W)
//   RESET_STATE 0   state value loaded on reset (STATE_W bits)
//   OSC_LIMIT   4   consecutive same-sel transitions that declare oscillation; range 2..255
//   CNT_W       8   width of the oscillation-event counter
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   1        sel is valid this cycle
//   sel        in   SEL_W    index of the state bit to toggle
//   in_ready   out  1        constant 1; every valid beat is consumed in the same cycle
//   y          out  1        Mealy output, combinational: in_valid & legal & sel[0]
//   state      out  STATE_W  current state register
//   err        out  1        sticky: an illegal sel was presented
//   osc_flag   out  1        registered: an oscillation run is active
//   osc_events out  CNT_W    oscillation run count; saturates at all-ones
// BEHAVIOUR
//   Reset values: state=RESET_STATE; err=0; osc_flag=0; osc_events=0; run=0; last_sel=0.
//   Reset is synchronous. Asserting rst mid-run clears everything on that edge.
//   rst has priority over every other event in the same cycle.
//   legal = (sel < STATE_W).
//   Accept = in_valid & legal. On an accept edge: state <= state ^ (1 << sel).
//     Latency is 1 cycle.
//   in_valid & !legal: state, run and osc_flag hold; err <= 1. err stays set until reset.
//   in_valid=0: all registers hold. Idle cycles do NOT break an oscillation run.
//   Oscillation tracking on each accept, using internal run counter run[7:0] and last_sel:
//     - run==0 or sel!=last_sel: run <= 1; osc_flag <= 0.
//     - sel==last_sel: run <= min(run+1, OSC_LIMIT).
//       osc_flag <= 1 when the new run value equals OSC_LIMIT.
//     - Every accept: last_sel <= sel.
//   Rising edge of osc_flag (0->1): osc_events increments once, saturating at 2**CNT_W-1.
//     It does not increment again while the run continues.
//   Two same-sel accepts return state to its start value, so the run means ping-pong
//     between exactly two states.
//   There are no unreachable or illegal states; all 2**STATE_W encodings are valid.
// CONFIGURATION
//   TWF_SOFT_CLR_EN
//     Defined: adds input port clr (1 bit).
//       clr & !rst acts exactly like rst for one cycle, but err is NOT cleared.
//       clr has priority over an accept in the same cycle.
//     Undefined: no clr port. Clearing is possible only via rst.
// TESTING
//   T1 2-bit equivalence. STATE_W=2, reset to 0. Drive sel sequence 0,1,0,1.
//      -> state 1,3,2,0; y 0,1,0,1.
//   T2 Oscillation. STATE_W=4, OSC_LIMIT=4. Drive sel=2 six times.
//      -> state alternates 0x4/0x0; osc_flag rises after the 4th accept edge and stays high;
//         osc_events=1. Then sel=1 -> osc_flag=0, state=0x2.
//   T3 Idle gap. Drive sel=3, 3, idle 5 cycles, then 3, 3 with OSC_LIMIT=4.
//      -> flag after the 4th accept; osc_events=1.
//   T4 Illegal sel. STATE_W=3, SEL_W=2, state=0x5. Drive sel=3.
//      -> state stays 0x5; err=1; y=0; run unchanged. Later accept sel=0 -> state=0x4;
//         err stays 1.
//   T5 Reset mid-run. Set run=3, then assert rst together with in_valid, sel=same.
//      -> next cycle state=RESET_STATE; all outputs 0.
//   T6 Saturation. CNT_W=2, OSC_LIMIT=2. Complete 5 separate runs.
//      -> osc_events=3 and holds at 3.
//      With TWF_SOFT_CLR_EN, assert clr -> osc_events=0 and err is retained.

Source files
------------

// File: rtl/toggle_walk_fsm.sv
// Sequence-driven state walker: each accepted sel toggles one state bit, with ping-pong detection.
// Optional soft clear port enabled by defining TWF_SOFT_CLR_EN.
module toggle_walk_fsm #(
   parameter int unsigned             STATE_W     = 2,
   parameter int unsigned             SEL_W       = 1,
   parameter logic [STATE_W-1:0]      RESET_STATE = '0,
   parameter int unsigned             OSC_LIMIT   = 4,
   parameter int unsigned             CNT_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
`ifdef TWF_SOFT_CLR_EN
   input  logic                clr,
`endif
   input  logic                in_valid,
   input  logic [SEL_W-1:0]    sel,
   output logic                in_ready,
   output logic                y,
   output logic [STATE_W-1:0]  state,
   output logic                err,
   output logic                osc_flag,
   output logic [CNT_W-1:0]    osc_events
);

   localparam int unsigned      RUN_W     = 8;
   localparam int unsigned      RUN_W1    = RUN_W + 1;
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(OSC_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [STATE_W-1:0] state_q, state_d;
   logic               err_q, err_d;
   logic               flag_q, flag_d;
   logic [CNT_W-1:0]   events_q, events_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [SEL_W-1:0]   last_sel_q, last_sel_d;

   logic               legal_c;
   logic               accept_c;
   logic               clear_c;
   logic [RUN_W:0]     run_inc_c;

   assign legal_c   = (32'(sel) < STATE_W);
   assign accept_c  = in_valid & legal_c;
   assign run_inc_c = {1'b0, run_q} + RUN_W1'(1);

`ifdef TWF_SOFT_CLR_EN
   assign clear_c = clr;
`else
   assign clear_c = 1'b0;
`endif

   // Next-state: soft clear wins over an accept; illegal selectors only set err
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      flag_d     = flag_q;
      events_d   = events_q;
      run_d      = run_q;
      last_sel_d = last_sel_q;

      if (clear_c) begin
         state_d    = RESET_STATE;
         flag_d     = 1'b0;
         events_d   = '0;
         run_d      = '0;
         last_sel_d = '0;
      end else if (in_valid) begin
         if (!legal_c) begin
            err_d = 1'b1;
         end else begin
            state_d    = state_q ^ (STATE_W'(1) << sel);
            last_sel_d = sel;
            if ((run_q == '0) || (sel != last_sel_q)) begin
               run_d  = RUN_W'(1);
               flag_d = 1'b0;
            end else begin
               if (run_inc_c >= {1'b0, RUN_LIMIT}) begin
                  run_d = RUN_LIMIT;
               end else begin
                  run_d = run_inc_c[RUN_W-1:0];
               end
               flag_d = (run_d == RUN_LIMIT);
            end
         end
      end

      // Count each new oscillation run once, on the flag's rising edge
      if (flag_d && !flag_q && (events_q != CNT_MAX)) begin
         events_d = events_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RESET_STATE;
         err_q      <= 1'b0;
         flag_q     <= 1'b0;
         events_q   <= '0;
         run_q      <= '0;
         last_sel_q <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         flag_q     <= flag_d;
         events_q   <= events_d;
         run_q      <= run_d;
         last_sel_q <= last_sel_d;
      end
   end

   assign in_ready   = 1'b1;
   assign y          = accept_c & sel[0];
   assign state      = state_q;
   assign err        = err_q;
   assign osc_flag   = flag_q;
   assign osc_events = events_q;

endmodule
